// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Round-robin arbiter and access sequencer for the single shared external
//   memory bus. One requester owns the bus at a time. Each transaction is a
//   one-word fixed-latency read or write, and it ends with a one-cycle done
//   pulse to the owner.
//
//   Handshake: a requester raises req[i] with addr/wdata/rw stable. Those
//   fields are sampled only on the edge that grants the bus. The owner sees
//   done[i] for exactly one cycle, and rdata is valid in that cycle for a read.
//   After done there is one turnaround cycle before the next arbitration, so
//   the owner can drop req. A req still held after done is a new request and
//   ranks last in the round-robin order.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   req/req_rw        per-requester request and direction (1 = write)
//   req_addr/wdata    packed per-requester fields, slot i at [i*W +: W]
//   grant/done        one-hot bus ownership / one-cycle completion pulse
//   rdata             read data captured at the done edge
//   mem_*             registered memory bus (enable, address, data, rw)
//   mem_rdata         memory read data, valid MEM_LATENCY edges after mem_en
//   busy              FSM is not IDLE
//   dbg_state         raw FSM state for observation
module mem_bus_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_WIDTH  = 9,
  parameter int DATA_WIDTH  = 8,
  parameter int MEM_LATENCY = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_REQ-1:0]            req_rw,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            done,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          mem_en,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  output logic                          mem_rw,
  input  logic [DATA_WIDTH-1:0]         mem_rdata,
  output logic                          busy,
  output logic [1:0]                    dbg_state
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [PTR_W-1:0]        last_ptr_q;
  logic [NUM_REQ-1:0]      grant_q;
  logic [NUM_REQ-1:0]      done_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    mem_en_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_wdata_q;
  logic                    mem_rw_q;
  logic                    busy_q;

  // Round-robin winner. Candidates are visited from the farthest slot to the
  // nearest one after last_ptr, so the nearest requesting slot overwrites the
  // others and wins.
  logic [PTR_W-1:0]   win_idx;
  logic               win_valid;
  logic [NUM_REQ-1:0] win_onehot;

  always_comb begin
    int s;
    s         = 0;
    win_idx   = '0;
    win_valid = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      s = int'(last_ptr_q) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      if (req[PTR_W'(s)]) begin
        win_idx   = PTR_W'(s);
        win_valid = 1'b1;
      end
    end
    win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_ptr_q  <= PTR_W'(NUM_REQ - 1);
      grant_q     <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rw_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_valid) begin
            grant_q     <= win_onehot;
            mem_en_q    <= 1'b1;
            mem_addr_q  <= req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata_q <= req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
            mem_rw_q    <= req_rw[win_idx];
            last_ptr_q  <= win_idx;
            cnt_q       <= CNT_W'(MEM_LATENCY - 1);
            busy_q      <= 1'b1;
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            // grant_q is the owner's one-hot, so done lands on the owner.
            done_q <= grant_q;
            if (!mem_rw_q) rdata_q <= mem_rdata;
            grant_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_rw_q    <= 1'b0;
            state_q     <= RELEASE;
          end
        end
        RELEASE: begin
          done_q  <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_rw    = mem_rw_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter. The main instance uses 2 requesters and a
// 2-cycle latency. It has a latency-accurate memory model and a
// transaction-timeline reference model that is compared every cycle. A
// second instance uses a 1-cycle latency and is checked against literal
// edge timing.
module tb_mem_bus_arbiter;
  localparam int NR = 2;
  localparam int AW = 9;
  localparam int DW = 8;
  localparam int L  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- main instance ----------------
  logic [NR-1:0]    req = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*DW-1:0] req_wdata = '0;
  logic [NR-1:0]    req_rw = '0;
  logic [NR-1:0]    grant, done;
  logic [DW-1:0]    rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]    mem_addr;
  logic             mem_en, mem_rw, busy;
  logic [1:0]       dbg_state;

  mem_bus_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rw(req_rw), .grant(grant), .done(done), .rdata(rdata), .mem_en(mem_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw), .mem_rdata(mem_rdata),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- latency-1 instance ----------------
  logic [NR-1:0]    b_req = '0;
  logic [NR*AW-1:0] b_req_addr = '0;
  logic [NR*DW-1:0] b_req_wdata = '0;
  logic [NR-1:0]    b_req_rw = '0;
  logic [NR-1:0]    b_grant, b_done;
  logic [DW-1:0]    b_rdata, b_mem_wdata, b_mem_rdata;
  logic [AW-1:0]    b_mem_addr;
  logic             b_mem_en, b_mem_rw, b_busy;
  logic [1:0]       b_dbg_state;

  mem_bus_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset), .req(b_req), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .req_rw(b_req_rw), .grant(b_grant), .done(b_done), .rdata(b_rdata), .mem_en(b_mem_en),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rw(b_mem_rw), .mem_rdata(b_mem_rdata),
    .busy(b_busy), .dbg_state(b_dbg_state)
  );

  assign b_mem_rdata = (b_mem_en && !b_mem_rw) ? (b_mem_addr[7:0] ^ 8'h5A) : 8'hFF;

  // ---------------- memory model (main instance) ----------------
  // Data is only presented in the cycle the access matures. In every other
  // cycle the inverted word is driven, so sampling on the wrong edge is caught.
  logic [DW-1:0] mem [0:511];
  logic [DW-1:0] ref_mem [0:511];
  int  age;
  bit  loaded = 1'b0;

  function automatic logic [DW-1:0] init_val(int i);
    if (i == 'h1A5) return 8'h3C;
    return 8'((i * 37 + 11) ^ (i >> 3));
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      age <= 0;
      if (!loaded) begin
        for (int i = 0; i < 512; i++) mem[i] <= init_val(i);
        loaded <= 1'b1;
      end
    end else if (mem_en) begin
      age <= age + 1;
      if (mem_rw && age == L - 1) mem[mem_addr] <= mem_wdata;
    end else begin
      age <= 0;
    end
  end

  assign mem_rdata = (mem_en && !mem_rw && age == L - 1) ? mem[mem_addr] : ~mem[mem_addr];

  // ---------------- scoreboard helpers ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + per-cycle compare ----------------
  // Timeline view: a transaction granted at edge t0 shows grant/mem_* on
  // edges t0..t0+L-1, done on edge t0+L and busy through t0+L. The next
  // arbitration is allowed from edge t0+L+2.
  logic [NR-1:0]    e_grant, e_done;
  logic [DW-1:0]    e_rdata = '0;
  logic             e_busy;
  logic [AW-1:0]    e_addr;
  logic [DW-1:0]    e_wdata;
  logic             e_rw;

  initial begin : model_and_compare
    int cyc, next_arb, t0, own, last, w, c;
    bit act;
    logic [NR-1:0]    s_req, s_rw;
    logic [NR*AW-1:0] s_addr;
    logic [NR*DW-1:0] s_wd;
    logic             s_rst;
    logic [AW-1:0]    taddr;
    logic [DW-1:0]    twd;
    logic             trw;
    cyc = 0; next_arb = 0; t0 = 0; own = 0; last = NR - 1; act = 1'b0;
    taddr = '0; twd = '0; trw = 1'b0;
    for (int i = 0; i < 512; i++) ref_mem[i] = init_val(i);
    forever begin
      @(posedge clk);
      s_req = req; s_rw = req_rw; s_addr = req_addr; s_wd = req_wdata; s_rst = reset;
      cyc++;
      if (s_rst) begin
        act = 1'b0; last = NR - 1; next_arb = cyc + 1; e_rdata = '0;
      end else begin
        if (act && cyc > t0 + L) act = 1'b0;
        if (!act && cyc >= next_arb && s_req != '0) begin
          w = -1;
          for (int k = 1; k <= NR; k++) begin
            c = (last + k) % NR;
            if (w < 0 && s_req[c]) w = c;
          end
          act = 1'b1; t0 = cyc; own = w; last = w; next_arb = cyc + L + 2;
          taddr = s_addr[w*AW +: AW]; twd = s_wd[w*DW +: DW]; trw = s_rw[w];
        end
        if (act && cyc == t0 + L) begin
          if (!trw) e_rdata = ref_mem[taddr];
          else      ref_mem[taddr] = twd;
        end
      end
      e_grant = (act && cyc < t0 + L) ? NR'(1 << own) : '0;
      e_done  = (act && cyc == t0 + L) ? NR'(1 << own) : '0;
      e_busy  = act && (cyc <= t0 + L);
      e_addr  = (e_grant != '0) ? taddr : '0;
      e_wdata = (e_grant != '0) ? twd : '0;
      e_rw    = (e_grant != '0) ? trw : 1'b0;
      #1;
      chk("grant",     32'(grant),     32'(e_grant));
      chk("done",      32'(done),      32'(e_done));
      chk("busy",      32'(busy),      32'(e_busy));
      chk("mem_en",    32'(mem_en),    32'(e_grant != '0));
      chk("mem_addr",  32'(mem_addr),  32'(e_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
      chk("mem_rw",    32'(mem_rw),    32'(e_rw));
      chk("rdata",     32'(rdata),     32'(e_rdata));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_slot(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rw);
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
    req_rw[i]             = rw;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int zeros, k;
    logic [NR-1:0] g, prev, exp_g;
    do_reset();

    // Reset values
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);

    // Single read of 0x1A5 by requester 0
    set_slot(0, 9'h1A5, 8'h00, 1'b0);
    req = 2'b01;
    tick();
    chk("rd_grant", 32'(grant), 32'h1);
    chk("rd_mem_en", 32'(mem_en), 32'h1);
    chk("rd_mem_addr", 32'(mem_addr), 32'h1A5);
    @(negedge clk) req = '0;
    tick(); tick();
    chk("rd_done", 32'(done), 32'h1);
    chk("rd_rdata", 32'(rdata), 32'h3C);
    chk("rd_grant_off", 32'(grant), 32'h0);
    tick();
    chk("rd_busy_off", 32'(busy), 32'h0);

    // Single write 0xA7 -> 0x004 by requester 1, then read it back
    @(negedge clk);
    set_slot(1, 9'h004, 8'hA7, 1'b1);
    req = 2'b10;
    tick();
    chk("wr_grant", 32'(grant), 32'h2);
    chk("wr_mem_rw", 32'(mem_rw), 32'h1);
    chk("wr_mem_wdata", 32'(mem_wdata), 32'hA7);
    @(negedge clk) req = '0;
    tick();
    chk("wr_mem_rw2", 32'(mem_rw), 32'h1);
    chk("wr_mem_wdata2", 32'(mem_wdata), 32'hA7);
    tick();
    chk("wr_done", 32'(done), 32'h2);
    tick();
    chk("wr_mem_cell", 32'(mem[4]), 32'hA7);
    @(negedge clk);
    set_slot(0, 9'h004, 8'h00, 1'b0);
    req = 2'b01;
    tick();
    @(negedge clk) req = '0;
    tick(); tick();
    chk("wr_readback", 32'(rdata), 32'hA7);
    tick();

    // Both requesting from reset: grants alternate with two idle cycles between
    do_reset();
    set_slot(0, 9'h010, 8'h11, 1'b0);
    set_slot(1, 9'h020, 8'h22, 1'b0);
    req = 2'b11;
    prev = '0; zeros = 0; k = 0;
    for (int e = 1; e <= 16; e++) begin
      tick();
      g = grant;
      if (g != '0 && prev == '0) begin
        exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
        chk("alt_seq", 32'(g), 32'(exp_g));
        if (k > 0) chk("alt_gap", 32'(zeros), 32'd2);
        k++;
        zeros = 0;
      end else if (g == '0) begin
        zeros++;
      end
      prev = g;
    end
    chk("alt_count", 32'(k), 32'd4);

    // Reset in the cycle after a grant: everything drops at once, no done
    do_reset();
    req = 2'b11;
    tick();
    chk("mid_grant", 32'(grant), 32'h1);
    tick();
    reset = 1'b1;
    #1;
    chk("mid_rst_grant", 32'(grant), 32'h0);
    chk("mid_rst_mem_en", 32'(mem_en), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_done", 32'(done), 32'h0);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    tick();
    chk("post_rst_winner", 32'(grant), 32'h1);
    @(negedge clk) req = '0;
    repeat (4) tick();
    @(negedge clk) req = 2'b10;
    tick();
    chk("post_rst_req1", 32'(grant), 32'h2);
    @(negedge clk) req = '0;
    repeat (4) tick();

    // Random traffic with occasional resets, checked by the model every cycle
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) req = NR'($urandom_range(0, 3));
      for (int i = 0; i < NR; i++)
        set_slot(i, AW'($urandom_range(0, 511)), DW'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end
    @(negedge clk);
    reset = 1'b0;
    req = '0;
    repeat (6) tick();

    // Latency-1 instance: back-to-back reads by requester 0
    @(negedge clk);
    b_req_addr[AW-1:0] = 9'h0C3;
    b_req_rw = '0;
    b_req = 2'b01;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk("l1_grant", 32'(b_grant), (e % 3 == 1) ? 32'h1 : 32'h0);
      chk("l1_done", 32'(b_done), (e % 3 == 2) ? 32'h1 : 32'h0);
      if (e % 3 == 2) chk("l1_rdata", 32'(b_rdata), 32'h99);
    end
    @(negedge clk) b_req = '0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
